// File: rtl/pool_tree.sv
// rtl/pool_tree.sv - pipelined max/floor-average pooling reduction tree with valid/ready
module pool_tree #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic                         in_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data
);
    localparam int L  = $clog2(NUM_IN);
    localparam int OW = DATA_WIDTH + L;

    logic                  w_advance;
    logic                  w_last_valid;
    logic                  w_last_mode;
    logic signed [OW-1:0]  w_last_node;
    logic [DATA_WIDTH-1:0] w_result;

    // Level k holds NUM_IN>>k nodes, each DATA_WIDTH+k bits so a full sum never overflows.
    // Max results ride the same widened nodes (sign-extended) so one datapath serves both modes.
    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int NN = NUM_IN >> k;
        localparam int W  = DATA_WIDTH + k;

        logic signed [W-2:0] w_child [2*NN];
        logic                w_child_valid;
        logic                w_child_mode;
        logic signed [W-1:0] w_next  [NN];
        logic signed [W-1:0] r_node  [NN];
        logic                r_valid;
        logic                r_mode;

        if (k == 1) begin : g_src
            for (genvar n = 0; n < 2*NN; n++) begin : g_in
                assign w_child[n] = in_data[n*DATA_WIDTH +: DATA_WIDTH];
            end
            assign w_child_valid = in_valid && in_ready;
            assign w_child_mode  = in_mode;
        end else begin : g_src
            for (genvar n = 0; n < 2*NN; n++) begin : g_in
                assign w_child[n] = g_lvl[k-1].r_node[n];
            end
            assign w_child_valid = g_lvl[k-1].r_valid;
            assign w_child_mode  = g_lvl[k-1].r_mode;
        end

        // The mode bit travelling with the window picks sum or max at every node,
        // so interleaved windows of different modes never mix.
        for (genvar n = 0; n < NN; n++) begin : g_node
            logic signed [W-1:0] w_a;
            logic signed [W-1:0] w_b;
            assign w_a       = {w_child[2*n][W-2], w_child[2*n]};
            assign w_b       = {w_child[2*n+1][W-2], w_child[2*n+1]};
            assign w_next[n] = w_child_mode ? (w_a + w_b) : ((w_a >= w_b) ? w_a : w_b);
        end

        // Level register: cleared by reset, otherwise loads only when the whole pipe advances.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_mode  <= 1'b0;
                for (int n = 0; n < NN; n++) begin
                    r_node[n] <= '0;
                end
            end else if (w_advance) begin
                r_valid <= w_child_valid;
                r_mode  <= w_child_mode;
                for (int n = 0; n < NN; n++) begin
                    r_node[n] <= w_next[n];
                end
            end
        end
    end

    assign w_last_valid = g_lvl[L].r_valid;
    assign w_last_mode  = g_lvl[L].r_mode;
    assign w_last_node  = g_lvl[L].r_node[0];

    // Arithmetic shift of the full sum floors toward minus infinity; the average always fits DATA_WIDTH.
    assign w_result = w_last_mode ? DATA_WIDTH'(w_last_node >>> L) : DATA_WIDTH'(w_last_node);

    // Output is masked while reset is held so an in-flight window never shows up as a partial result.
    assign out_valid = w_last_valid && !reset;
    assign out_data  = reset ? '0 : w_result;

    // Global stall: every level moves together, so bubbles are carried rather than collapsed.
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance && !reset;

endmodule
